// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS pipeline.
// Drives a req/ack data-memory bus and stalls the upstream pipeline while a
// load or store is outstanding. Optional bus timeout with abort is enabled by
// defining MEM_TIMEOUT_EN; without it REQ waits for DmAck indefinitely.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ExMemWb,
    input  logic        ExMemRead,
    input  logic        ExMemWrite,
    input  logic [31:0] ExMemAdr,
    input  logic [31:0] ExMemWriteD,
    input  logic [4:0]  ExMemRd,
    output logic [3:0]  MemWb,
    output logic [31:0] MemReadD,
    output logic [31:0] MemAdr,
    output logic [4:0]  MemRd,
    output logic        MemStall,
    output logic        MemErr,
    output logic        DmReq,
    output logic        DmWe,
    output logic [31:0] DmAdr,
    output logic [31:0] DmWData,
    input  logic [31:0] DmRData,
    input  logic        DmAck
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] r_data_q, r_data_d;
    logic        mem_op;
    logic        is_store;

    // A store wins when both read and write are requested.
    assign mem_op   = ExMemRead | ExMemWrite;
    assign is_store = ExMemWrite;

`ifdef MEM_TIMEOUT_EN
    localparam int         TIMEOUT = 15;
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    logic [3:0] to_cnt_q, to_cnt_d;
    logic       mem_err_q, mem_err_d;
`endif

    // State, captured read data and optional timeout bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            r_data_q  <= 32'd0;
`ifdef MEM_TIMEOUT_EN
            to_cnt_q  <= 4'd0;
            mem_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            r_data_q  <= r_data_d;
`ifdef MEM_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            mem_err_q <= mem_err_d;
`endif
        end
    end

    // Next-state logic: one IDLE stall cycle, REQ until ack (or abort), one DONE cycle.
    always_comb begin
        state_d   = state_q;
        r_data_d  = r_data_q;
`ifdef MEM_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        mem_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d  = REQ;
`ifdef MEM_TIMEOUT_EN
                    to_cnt_d = 4'd0;
`endif
                end
            end
            REQ: begin
                if (DmAck) begin
                    state_d  = DONE;
                    r_data_d = is_store ? 32'd0 : DmRData;
                end
`ifdef MEM_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d   = DONE;
                    r_data_d  = 32'hDEADBEEF;
                    mem_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 4'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: pass-through, bubble while stalled, bus drive only in REQ; all zero in reset.
    always_comb begin
        MemWb    = 4'd0;
        MemReadD = 32'd0;
        MemAdr   = 32'd0;
        MemRd    = 5'd0;
        MemStall = 1'b0;
        DmReq    = 1'b0;
        DmWe     = 1'b0;
        DmAdr    = 32'd0;
        DmWData  = 32'd0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    MemAdr = ExMemAdr;
                    MemRd  = ExMemRd;
                    if (mem_op) begin
                        MemStall = 1'b1;
                    end else begin
                        MemWb = ExMemWb;
                    end
                end
                REQ: begin
                    MemAdr   = ExMemAdr;
                    MemRd    = ExMemRd;
                    MemStall = 1'b1;
                    DmReq    = 1'b1;
                    DmWe     = is_store;
                    DmAdr    = ExMemAdr;
                    DmWData  = ExMemWriteD;
                end
                DONE: begin
                    MemWb    = ExMemWb;
                    MemAdr   = ExMemAdr;
                    MemRd    = ExMemRd;
                    MemReadD = r_data_q;
                end
                default: begin
                    MemStall = 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    assign MemErr = rst & mem_err_q;
`else
    assign MemErr = 1'b0;
`endif

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register. Drives a variable-latency data-memory bus with a req/ack handshake and stalls the upstream pipeline while a load or store is outstanding. It forwards the write-back control, ALU address and destination register to the MEM/WB register, together with load data. A bubble is presented to MEM/WB for every stall cycle.

## Interface
- TIMEOUT, 15: max REQ cycles without DmAck before abort; only used with MEM_TIMEOUT_EN.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- ExMemWb  in  4  write-back control from EX/MEM.
- ExMemRead  in  1  load request.
- ExMemWrite  in  1  store request.
- ExMemAdr  in  32  ALU result / memory address.
- ExMemWriteD  in  32  store data.
- ExMemRd  in  5  destination register.
- MemWb  out  4  write-back control to MEM/WB.
- MemReadD  out  32  load data to MEM/WB.
- MemAdr  out  32  ALU result to MEM/WB.
- MemRd  out  5  destination register to MEM/WB.
- MemStall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- MemErr  out  1  one-cycle pulse on bus timeout; tied 0 without MEM_TIMEOUT_EN.
- DmReq  out  1  bus request.
- DmWe  out  1  1 = write, 0 = read.
- DmAdr  out  32  bus address.
- DmWData  out  32  bus write data.
- DmRData  in  32  bus read data, valid with DmAck.
- DmAck  in  1  bus completion, one cycle.

## Operation
- Memory op = ExMemRead | ExMemWrite. If both are set, the op is a store: DmWe=1 and MemReadD=0.
- FSM states: IDLE, REQ, DONE. Registers: state, RDataQ[31:0], TOCnt[3:0] (with macro), MemErr.
- IDLE, no memory op:
  - MemWb/MemAdr/MemRd pass ExMem* through combinationally.
  - MemReadD=0, MemStall=0.
- IDLE, memory op:
  - MemStall=1, MemWb=0 (bubble); next state is REQ.
- REQ:
  - DmReq=1, DmWe=ExMemWrite, DmAdr=ExMemAdr, DmWData=ExMemWriteD.
  - MemStall=1, MemWb=0.
  - On DmAck: RDataQ<=DmRData for loads, 0 for stores; next state is DONE.
- DONE:
  - MemStall=0; MemWb/MemAdr/MemRd=ExMem*, MemReadD=RDataQ.
  - Next state is IDLE unconditionally. EX/MEM advances at the end of this cycle.
- Outside REQ: DmReq=0, DmWe=0, DmAdr=0, DmWData=0. DmAck outside REQ is ignored.
- Upstream contract: EX/MEM holds all ExMem* inputs stable while MemStall=1.

## Timing
- While rst=0, every output is 0: MemWb, MemReadD, MemAdr, MemRd, MemStall, MemErr, DmReq, DmWe, DmAdr, DmWData.
- While rst=0, state=IDLE, RDataQ=0, TOCnt=0.
- Reset mid-REQ drops DmReq immediately (async) and abandons the transaction. A late DmAck is ignored.
- Latency, with DmAck arriving k≥0 cycles after DmReq first rises:
  - Stall cycles = 2+k (IDLE cycle + 1+k REQ cycles).
  - Result is presented in DONE; MEM/WB captures it on the DONE→IDLE edge.
- Minimum: DmAck in the first REQ cycle gives 2 stall cycles; the data is in MEM/WB 3 edges after the op reaches the stage.
- Back-to-back memory ops: after DONE, the next op sees IDLE and stalls again. There is no overlap, and at most one transaction is outstanding.
- Non-memory ops: zero added latency, no stall.

## Configuration
- MEM_TIMEOUT_EN defined:
  - TOCnt clears on REQ entry and increments each REQ cycle without DmAck.
  - When TOCnt reaches TIMEOUT-1 without DmAck: DmReq drops, RDataQ<=32'hDEADBEEF, MemErr=1 for the next cycle (the DONE cycle), then DONE→IDLE as normal.
  - DmAck in the same cycle as the limit wins: normal completion, no MemErr.
- MEM_TIMEOUT_EN undefined:
  - No counter; REQ waits for DmAck indefinitely. MemErr is constant 0.

## Test plan
- Reset low mid-REQ with DmAck held off -> DmReq, MemStall, all outputs 0 immediately; after release with no op, outputs track ExMem*.
- ALU op (ExMemRead=0, ExMemWrite=0, ExMemAdr=32'h10, ExMemRd=5, ExMemWb=4'b1001) -> MemStall=0, same values on Mem* the same cycle, MemReadD=0.
- Load ExMemAdr=32'h40 with DmAck 3 cycles after DmReq, DmRData=32'hCAFEF00D -> MemStall high 5 cycles with MemWb=0; then DONE with MemReadD=32'hCAFEF00D, MemAdr=32'h40.
- Store ExMemWriteD=32'h12345678 with ack in the first REQ cycle -> DmWe=1, DmWData=32'h12345678, 2 stall cycles, MemReadD=0; a stray DmAck in IDLE afterwards causes no state change.
- Back-to-back loads, ack k=0 then k=1 -> stall runs of 2 and 3 cycles separated by one DONE cycle; each DONE carries its own data.
- With MEM_TIMEOUT_EN and TIMEOUT=15, no DmAck -> DmReq for 15 cycles, then MemReadD=32'hDEADBEEF with a single-cycle MemErr pulse; FSM returns to IDLE.
